ones_pattern_gen: RTL and testbench



---
 rtl/ones_pattern_gen_pkg.sv | 28 ++
 rtl/comb_next.sv | 26 ++
 rtl/ones_pattern_gen.sv | 97 +++++++++
 tb/tb_ones_pattern_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ones_pattern_gen_pkg.sv
// Shared types, widths and mask helpers for the fixed-popcount pattern generator.
package ones_pattern_gen_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned IDX_W    = 7;
   localparam int unsigned MAX_ONES = 8;

   typedef enum logic [0:0] {
      IDLE,
      EMIT
   } state_e;

   // Smallest word with n ones: the n low bits set.
   function automatic logic [DATA_W-1:0] low_mask(input logic [CNT_W-1:0] n);
      logic [DATA_W-1:0] ones;
      ones = '1;
      return ~(ones << n);
   endfunction

   // Largest word with n ones: the n high bits set; marks the final beat.
   function automatic logic [DATA_W-1:0] top_mask(input logic [CNT_W-1:0] n);
      logic [DATA_W-1:0] ones;
      ones = '1;
      return ~(ones >> n);
   endfunction

endpackage

// File: rtl/comb_next.sv
// Next larger 8-bit word with the same popcount (lexicographic next combination).
module comb_next
   import ones_pattern_gen_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   output logic [DATA_W-1:0] next_o
);

   logic [DATA_W-1:0] lsb;
   logic [DATA_W-1:0] ripple;
   logic [DATA_W-1:0] tail;
   logic [2:0]        tz;

   // Shift by the trailing-zero count stands in for dividing by the lowest set bit.
   always_comb begin
      lsb    = word_i & (~word_i + 8'd1);
      ripple = word_i + lsb;
      tz     = '0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (word_i[i]) tz = 3'(i);
      end
      tail   = ((ripple ^ word_i) >> 2) >> tz;
      next_o = ripple | tail;
   end

endmodule

// File: rtl/ones_pattern_gen.sv
// Streams every 8-bit word with exactly N ones, ascending, over a valid/ready handshake.
module ones_pattern_gen
   import ones_pattern_gen_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  count_in,
   input  logic              ready,
   output logic [DATA_W-1:0] pattern,
   output logic              valid,
   output logic              last,
   output logic [IDX_W-1:0]  index,
   output logic              busy,
   output logic              err
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [DATA_W-1:0] pattern_q, pattern_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic              last_q, last_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] next_word;

   comb_next u_comb_next (
      .word_i (pattern_q),
      .next_o (next_word)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      pattern_d = pattern_q;
      index_d   = index_q;
      last_d    = last_q;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (count_in <= CNT_W'(MAX_ONES)) begin
                  state_d   = EMIT;
                  n_d       = count_in;
                  pattern_d = low_mask(count_in);
                  index_d   = '0;
                  last_d    = (low_mask(count_in) == top_mask(count_in));
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         EMIT: begin
            if (ready) begin
               if (last_q) begin
                  state_d   = IDLE;
                  pattern_d = '0;
                  index_d   = '0;
                  last_d    = 1'b0;
               end else begin
                  // next_word is only meaningful here: last_q=0 rules out the overflow case.
                  pattern_d = next_word;
                  index_d   = index_q + 7'd1;
                  last_d    = (next_word == top_mask(n_q));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         n_q       <= '0;
         pattern_q <= '0;
         index_q   <= '0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         pattern_q <= pattern_d;
         index_q   <= index_d;
         last_q    <= last_d;
         err_q     <= err_d;
      end
   end

   assign pattern = pattern_q;
   assign index   = index_q;
   assign last    = last_q;
   assign err     = err_q;
   assign valid   = (state_q == EMIT);
   assign busy    = (state_q == EMIT);

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed and randomized checks of ones_pattern_gen against a popcount-enumeration model.
module tb_ones_pattern_gen;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] count_in;
   logic       ready;
   logic [7:0] pattern;
   logic       valid;
   logic       last;
   logic [6:0] index;
   logic       busy;
   logic       err;

   int n_checks;
   int n_fail;

   ones_pattern_gen dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .count_in (count_in),
      .ready    (ready),
      .pattern  (pattern),
      .valid    (valid),
      .last     (last),
      .index    (index),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Drives one sequence and checks every beat against the ascending list of
   // all 8-bit words with popcount n. Returns the number of beats transferred.
   task automatic run_seq(input int n, input int stall_pct, input int stall_at,
                          input int stall_len, input int abort_after, input bit poke_start,
                          output int beats);
      logic [7:0] exp_q[$];
      int k, stalled, budget;
      bit done;
      for (int v = 0; v < 256; v++) begin
         if ($countones(v[7:0]) == n) exp_q.push_back(v[7:0]);
      end
      @(negedge clk);
      start = 1'b1; count_in = 4'(n); ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0; stalled = 0; budget = 0; beats = 0; done = 1'b0;
      while (!done) begin
         check("valid", valid, 1);
         check("busy", busy, 1);
         check("err_in_emit", err, 0);
         check("pattern", pattern, exp_q[k]);
         check("index", index, k);
         check("last", last, (k == exp_q.size() - 1));
         check("popcount", $countones(pattern), n);
         if (abort_after >= 0 && k == abort_after) return;
         if (k == stall_at && stalled < stall_len) begin
            ready = 1'b0;
            stalled++;
         end else begin
            ready = ($urandom_range(0, 99) >= stall_pct);
         end
         if (poke_start) begin
            start    = 1'($urandom_range(0, 1));
            count_in = 4'($urandom_range(0, 15));
         end
         if (ready) begin
            if (k == exp_q.size() - 1) done = 1'b1;
            k++;
            beats++;
         end
         budget++;
         if (budget > 2000) begin
            check("timeout", 0, 1);
            start = 1'b0;
            return;
         end
         @(negedge clk);
      end
      start = 1'b0;
      ready = 1'b0;
      check_idle("after_last");
      check("err_after_last", err, 0);
   endtask

   initial begin
      int beats;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      count_in = '0;
      ready    = 1'b0;

      #12;
      check_idle("reset");
      check("reset_pattern", pattern, 8'h00);
      check("reset_index", index, 0);
      check("reset_last", last, 0);
      check("reset_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      // N=0 and N=8: single beat each
      run_seq(0, 0, -1, 0, -1, 1'b0, beats);
      check("beats_n0", beats, 1);
      run_seq(8, 0, -1, 0, -1, 1'b0, beats);
      check("beats_n8", beats, 1);

      // N=3 full stream with continuous ready
      run_seq(3, 0, -1, 0, -1, 1'b0, beats);
      check("beats_n3", beats, 56);

      // N=4 with random back-pressure and starts poked mid-sequence
      run_seq(4, 30, -1, 0, -1, 1'b1, beats);
      check("beats_n4", beats, 70);

      // N=2 stalled 5 cycles on 8'h0A (index 4)
      run_seq(2, 0, 4, 5, -1, 1'b0, beats);
      check("beats_n2", beats, 28);

      // Illegal counts
      for (int c = 9; c < 16; c++) begin
         @(negedge clk);
         start = 1'b1; count_in = 4'(c);
         @(negedge clk);
         start = 1'b0;
         check("err_pulse", err, 1);
         check_idle("err_cycle");
         @(negedge clk);
         check("err_clear", err, 0);
         check_idle("err_after");
      end

      // Asynchronous reset after 10 beats of N=4, then restart
      run_seq(4, 0, -1, 0, 10, 1'b0, beats);
      #2 reset = 1'b1;
      #1;
      check_idle("midreset");
      check("midreset_pattern", pattern, 8'h00);
      check("midreset_index", index, 0);
      check("midreset_last", last, 0);
      @(negedge clk);
      reset = 1'b0;
      ready = 1'b1;
      @(negedge clk);
      check_idle("no_resume");
      run_seq(4, 0, -1, 0, -1, 1'b0, beats);
      check("beats_restart", beats, 70);

      // Randomized sequences
      for (int r = 0; r < 8; r++) begin
         int n;
         int expect_beats;
         n = $urandom_range(0, 8);
         expect_beats = 0;
         for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == n) expect_beats++;
         end
         run_seq(n, $urandom_range(0, 60), -1, 0, -1, 1'b1, beats);
         check("beats_rand", beats, expect_beats);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
